// File: rtl/mem_stage_pkg.sv
// Shared RV32I types for the memory stage: FSM state, load/store funct3 encodings
// and helpers that derive the byte offset and misalignment from funct3 size bits.
package rv32i_types;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_t;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    ST_B = 3'b000,
    ST_H = 3'b001,
    ST_W = 3'b010
  } store_funct3_t;

  // Offset is truncated to the access size: halves keep addr[1], words use lane 0.
  function automatic logic [1:0] access_offset(input logic [1:0] size,
                                               input logic [1:0] addr_lo);
    case (size)
      2'b00:   access_offset = addr_lo;
      2'b01:   access_offset = {addr_lo[1], 1'b0};
      default: access_offset = 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    case (size)
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load extraction: shifts the addressed byte/half to lane 0 and
// sign- or zero-extends it according to funct3; zero latency, no handshake.
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    data = rdata;
    case (funct3)
      LD_B:    data = {{24{lane[7]}}, lane[7:0]};
      LD_H:    data = {{16{lane[15]}}, lane[15:0]};
      LD_BU:   data = {24'h0, lane[7:0]};
      LD_HU:   data = {16'h0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: one dmem req/resp per load/store; result 1 cycle after capture or after dmem_resp.
// Stalls execute while a request is outstanding. Optional MEM_MISALIGN_TRAP_EN adds misalign_err.
module mem_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_mem_valid,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] rs2_in,
  input  logic        br_en_in,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  output logic [31:0] mem_data_out,
  output logic        br_en_out,
  output logic [31:0] mem_fwd_data,
  output logic        mem_rdy,
  output logic        mem_stall
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rs2_q, rs2_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        br_en_q, br_en_d;
  logic        is_load_q, is_load_d;
  logic        is_store_q, is_store_d;

  logic        capture;
  logic        mem_op;
  logic        misalign_now;
  logic [1:0]  offset;
  logic [31:0] load_data;
  logic [3:0]  store_mask;

  assign mem_op  = mem_read_in || mem_write_in;
  assign capture = exe_mem_valid && !mem_stall &&
                   ((state_q == MEM_IDLE) || (state_q == MEM_DONE));
  assign offset  = access_offset(funct3_q[1:0], addr_q[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign misalign_now = mem_op && misaligned(funct3_in[1:0], alu_in[1:0]);

  always_comb begin
    misalign_d = misalign_q;
    if (capture) misalign_d = misalign_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign misalign_err = (state_q == MEM_DONE) && misalign_q;
`else
  assign misalign_now = 1'b0;
`endif

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (offset),
    .funct3 (funct3_q),
    .data   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rs2_d      = rs2_q;
    data_d     = data_q;
    funct3_d   = funct3_q;
    br_en_d    = br_en_q;
    is_load_d  = is_load_q;
    is_store_d = is_store_q;
    case (state_q)
      MEM_IDLE, MEM_DONE: begin
        if (capture) begin
          addr_d     = alu_in;
          rs2_d      = rs2_in;
          data_d     = alu_in;
          funct3_d   = funct3_in;
          br_en_d    = br_en_in;
          // A load wins when both read and write are flagged.
          is_load_d  = mem_read_in;
          is_store_d = mem_write_in && !mem_read_in;
          state_d    = (mem_op && !misalign_now) ? MEM_ACCESS : MEM_DONE;
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_ACCESS: begin
        if (dmem_resp) begin
          if (is_load_q) data_d = load_data;
          state_d = MEM_DONE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MEM_IDLE;
      addr_q     <= 32'h0;
      rs2_q      <= 32'h0;
      data_q     <= 32'h0;
      funct3_q   <= 3'b000;
      br_en_q    <= 1'b0;
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rs2_q      <= rs2_d;
      data_q     <= data_d;
      funct3_q   <= funct3_d;
      br_en_q    <= br_en_d;
      is_load_q  <= is_load_d;
      is_store_q <= is_store_d;
    end
  end

  always_comb begin
    store_mask = 4'b1111;
    case (funct3_q)
      ST_B:    store_mask = 4'b0001 << offset;
      ST_H:    store_mask = 4'b0011 << offset;
      default: store_mask = 4'b1111;
    endcase
  end

  assign dmem_read    = (state_q == MEM_ACCESS) && is_load_q;
  assign dmem_write   = (state_q == MEM_ACCESS) && is_store_q;
  assign dmem_address = {addr_q[31:2], 2'b00};
  assign dmem_wmask   = dmem_write ? store_mask : 4'b0000;
  assign dmem_wdata   = rs2_q << {offset, 3'b000};

  // Stall drops combinationally with dmem_resp so execute can advance into DONE.
  assign mem_stall    = (state_q == MEM_ACCESS) && !dmem_resp;
  assign mem_rdy      = (state_q == MEM_DONE);
  assign mem_data_out = data_q;
  assign mem_fwd_data = data_q;
  assign br_en_out    = br_en_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboard of expected writeback results checked on mem_rdy,
// plus inline request/timing checks per scenario.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        exe_mem_valid;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_in;
  logic [31:0] rs2_in;
  logic        br_en_in;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] mem_data_out;
  logic        br_en_out;
  logic [31:0] mem_fwd_data;
  logic        mem_rdy;
  logic        mem_stall;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        br;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [2:0]  ld_f3    [0:5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
  logic [31:0] ld_addr  [0:5] = '{32'h103, 32'h102, 32'h002, 32'h000, 32'h004, 32'h101};
  logic [31:0] ld_rdata [0:5] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_7FFF,
                                  32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_7F00};
  logic [31:0] ld_exp   [0:5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_8001,
                                  32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_007F};
  int          ld_lat   [0:5] = '{3, 1, 2, 4, 1, 2};

  logic [2:0]  st_f3    [0:3] = '{3'b000, 3'b001, 3'b010, 3'b000};
  logic [31:0] st_addr  [0:3] = '{32'h001, 32'h202, 32'h300, 32'h003};
  logic [31:0] st_rs2   [0:3] = '{32'h0000_00A5, 32'hABCD_1234, 32'hCAFE_F00D, 32'h1122_3344};
  logic [3:0]  st_mask  [0:3] = '{4'b0010, 4'b1100, 4'b1111, 4'b1000};
  logic [31:0] st_wdata [0:3] = '{32'h0000_A500, 32'h1234_0000, 32'hCAFE_F00D, 32'h4400_0000};
  int          st_lat   [0:3] = '{2, 3, 1, 2};

  mem_stage dut (
    .clk           (clk),
    .rst           (rst),
    .exe_mem_valid (exe_mem_valid),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .funct3_in     (funct3_in),
    .alu_in        (alu_in),
    .rs2_in        (rs2_in),
    .br_en_in      (br_en_in),
    .dmem_rdata    (dmem_rdata),
    .dmem_resp     (dmem_resp),
    .dmem_address  (dmem_address),
    .dmem_read     (dmem_read),
    .dmem_write    (dmem_write),
    .dmem_wmask    (dmem_wmask),
    .dmem_wdata    (dmem_wdata),
    .mem_data_out  (mem_data_out),
    .br_en_out     (br_en_out),
    .mem_fwd_data  (mem_fwd_data),
    .mem_rdy       (mem_rdy),
    .mem_stall     (mem_stall)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_err  (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard: every mem_rdy pulse consumes the oldest expected result.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_rdy === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rdy_unexpected: mem_rdy=1 data=%h with no outstanding instruction", mem_data_out);
      end else begin
        mon_e = sb_q.pop_front();
        if (mem_data_out !== mon_e.data || mem_fwd_data !== mon_e.data || br_en_out !== mon_e.br) begin
          errors++;
          $display("FAIL writeback: data=%h fwd=%h br=%b, want data=%h br=%b",
                   mem_data_out, mem_fwd_data, br_en_out, mon_e.data, mon_e.br);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic br);
    mem_read_in   = rd;
    mem_write_in  = wr;
    funct3_in     = f3;
    alu_in        = a;
    rs2_in        = d;
    br_en_in      = br;
    exe_mem_valid = 1'b1;
  endtask

  task automatic scramble();
    exe_mem_valid = 1'b0;
    mem_read_in   = 1'($urandom);
    mem_write_in  = 1'($urandom);
    funct3_in     = 3'($urandom);
    alu_in        = $urandom;
    rs2_in        = $urandom;
    br_en_in      = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    exe_mem_valid = 1'b0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'b000;
    alu_in = 32'h0; rs2_in = 32'h0; br_en_in = 1'b0;
    dmem_rdata = 32'h0; dmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dmem_read, dmem_write, dmem_wmask, mem_rdy, mem_stall, br_en_out} !== 9'h0) begin
      errors++;
      $display("FAIL reset_ctrl: read=%b write=%b wmask=%b rdy=%b stall=%b br=%b, want all 0",
               dmem_read, dmem_write, dmem_wmask, mem_rdy, mem_stall, br_en_out);
    end
    checks++;
    if (dmem_address !== 32'h0 || dmem_wdata !== 32'h0 || mem_data_out !== 32'h0 || mem_fwd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h data=%h fwd=%h, want all 0",
               dmem_address, dmem_wdata, mem_data_out, mem_fwd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_non_mem();
    logic [31:0] a;
    logic        br;
    for (int i = 0; i < 2; i++) begin
      a  = (i == 0) ? 32'h0000_1234 : 32'hFFFF_FFFF;
      br = (i == 0);
      @(negedge clk);
      issue(1'b0, 1'b0, 3'b010, a, 32'h5555_5555, br);
      sb_q.push_back('{a, br});
      @(negedge clk);
      scramble();
      checks++;
      if (mem_rdy !== 1'b1 || dmem_read !== 1'b0 || dmem_write !== 1'b0 || mem_stall !== 1'b0) begin
        errors++;
        $display("FAIL non_mem[%0d]: rdy=%b read=%b write=%b stall=%b, want rdy=1 others 0",
                 i, mem_rdy, dmem_read, dmem_write, mem_stall);
      end
    end
  endtask

  task automatic test_loads();
    int stall_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(1'b1, 1'b0, ld_f3[i], ld_addr[i], 32'h0, 1'(i));
      sb_q.push_back('{ld_exp[i], 1'(i)});
      @(negedge clk);
      scramble();
      stall_cnt = 0;
      for (int c = 0; c < ld_lat[i]; c++) begin
        checks++;
        if (dmem_read !== 1'b1 || dmem_write !== 1'b0 || dmem_address !== {ld_addr[i][31:2], 2'b00}) begin
          errors++;
          $display("FAIL load_req[%0d]: read=%b write=%b addr=%h, want read=1 write=0 addr=%h",
                   i, dmem_read, dmem_write, dmem_address, {ld_addr[i][31:2], 2'b00});
        end
        if (mem_stall === 1'b1) stall_cnt++;
        @(negedge clk);
      end
      dmem_rdata = ld_rdata[i];
      dmem_resp  = 1'b1;
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin
        errors++;
        $display("FAIL load_stall_fall[%0d]: stall=%b during resp, want 0", i, mem_stall);
      end
      @(negedge clk);
      dmem_resp  = 1'b0;
      dmem_rdata = $urandom;
      checks++;
      if (mem_rdy !== 1'b1 || dmem_read !== 1'b0) begin
        errors++;
        $display("FAIL load_rdy[%0d]: rdy=%b read=%b, want rdy=1 read=0", i, mem_rdy, dmem_read);
      end
      checks++;
      if (stall_cnt !== ld_lat[i]) begin
        errors++;
        $display("FAIL load_stall_cycles[%0d]: %0d cycles, want %0d", i, stall_cnt, ld_lat[i]);
      end
    end
  endtask

  task automatic test_stores();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      issue(1'b0, 1'b1, st_f3[i], st_addr[i], st_rs2[i], 1'(~i));
      sb_q.push_back('{st_addr[i], 1'(~i)});
      @(negedge clk);
      scramble();
      for (int c = 0; c < st_lat[i]; c++) begin
        checks++;
        if (dmem_write !== 1'b1 || dmem_read !== 1'b0 || mem_stall !== 1'b1 ||
            dmem_address !== {st_addr[i][31:2], 2'b00} ||
            dmem_wmask !== st_mask[i] || dmem_wdata !== st_wdata[i]) begin
          errors++;
          $display("FAIL store_req[%0d]: write=%b read=%b stall=%b addr=%h mask=%b wdata=%h, want 1 0 1 %h %b %h",
                   i, dmem_write, dmem_read, mem_stall, dmem_address, dmem_wmask, dmem_wdata,
                   {st_addr[i][31:2], 2'b00}, st_mask[i], st_wdata[i]);
        end
        @(negedge clk);
      end
      dmem_resp = 1'b1;
      @(negedge clk);
      dmem_resp = 1'b0;
      checks++;
      if (mem_rdy !== 1'b1 || dmem_write !== 1'b0 || dmem_wmask !== 4'b0000) begin
        errors++;
        $display("FAIL store_done[%0d]: rdy=%b write=%b mask=%b, want rdy=1 write=0 mask=0000",
                 i, mem_rdy, dmem_write, dmem_wmask);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 1'b0);
    sb_q.push_back('{32'h0000_8001, 1'b0});
    @(negedge clk);
    scramble();
    @(negedge clk);
    dmem_rdata = 32'h0000_8001;
    dmem_resp  = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    checks++;
    if (mem_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_rdy: rdy=%b, want 1", mem_rdy);
    end
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0008, 32'h0, 1'b1);
    sb_q.push_back('{32'h1357_9BDF, 1'b1});
    @(negedge clk);
    scramble();
    checks++;
    if (dmem_read !== 1'b1 || dmem_address !== 32'h0000_0008 || mem_stall !== 1'b1 || mem_rdy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_req: read=%b addr=%h stall=%b rdy=%b, want read=1 addr=00000008 stall=1 rdy=0",
               dmem_read, dmem_address, mem_stall, mem_rdy);
    end
    @(negedge clk);
    dmem_rdata = 32'h1357_9BDF;
    dmem_resp  = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    checks++;
    if (mem_rdy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_rdy: rdy=%b, want 1", mem_rdy);
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1'b1);
    @(negedge clk);
    scramble();
    checks++;
    if (dmem_read !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: read=%b, want 1", dmem_read);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dmem_read !== 1'b0 || mem_stall !== 1'b0 || mem_rdy !== 1'b0 || dmem_address !== 32'h0 ||
        mem_data_out !== 32'h0 || br_en_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: read=%b stall=%b rdy=%b addr=%h data=%h br=%b, want all 0",
               dmem_read, mem_stall, mem_rdy, dmem_address, mem_data_out, br_en_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmem_rdata = 32'hFFFF_FFFF;
    dmem_resp  = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (mem_rdy !== 1'b0 || mem_stall !== 1'b0 || dmem_read !== 1'b0 || mem_data_out !== 32'h0) begin
        errors++;
        $display("FAIL rst_stray_resp[%0d]: rdy=%b stall=%b read=%b data=%h, want 0 0 0 00000000",
                 c, mem_rdy, mem_stall, dmem_read, mem_data_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 1'b0);
    sb_q.push_back('{32'h0000_0101, 1'b0});
    @(negedge clk);
    scramble();
    checks++;
    if (dmem_read !== 1'b0 || mem_rdy !== 1'b1 || misalign_err !== 1'b1 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL misalign_trap: read=%b rdy=%b err=%b stall=%b, want read=0 rdy=1 err=1 stall=0",
               dmem_read, mem_rdy, misalign_err, mem_stall);
    end
    @(negedge clk);
    checks++;
    if (misalign_err !== 1'b0 || mem_rdy !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse: err=%b rdy=%b, want 0 0", misalign_err, mem_rdy);
    end
`else
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0, 1'b0);
    sb_q.push_back('{32'h0000_1234, 1'b0});
    @(negedge clk);
    scramble();
    checks++;
    if (dmem_read !== 1'b1 || dmem_address !== 32'h0000_0000) begin
      errors++;
      $display("FAIL misalign_trunc_req: read=%b addr=%h, want read=1 addr=00000000", dmem_read, dmem_address);
    end
    dmem_rdata = 32'h1234_5678;
    dmem_resp  = 1'b1;
    @(negedge clk);
    dmem_resp = 1'b0;
    checks++;
    if (mem_rdy !== 1'b1) begin
      errors++;
      $display("FAIL misalign_trunc_rdy: rdy=%b, want 1", mem_rdy);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_loads();
    test_stores();
    test_back_to_back();
    test_reset_mid_access();
    test_misalign();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never produced, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
